inertial_read_sequencer: RTL and testbench
==========================================

INERTIAL_READ_SEQUENCER -- requirements
Module: inertial_read_sequencer

Interface
REQ-001 SHALL have parameter FAST_SIM, default 0; when 1, the init timer is 9 bits instead of 16.
REQ-002 SHALL have input clk, 1 bit: system clock, all flops on its rising edge.
REQ-003 SHALL have input rst_n, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have input INT, 1 bit: sensor data-ready interrupt, asynchronous to clk.
REQ-005 SHALL have output wrt, 1 bit: one-cycle pulse starting an SPI transaction.
REQ-006 SHALL have output cmd, 16 bits: SPI command word; {addr, data} for writes, {addr|0x80, 0x00} for reads.
REQ-007 SHALL have input done, 1 bit: one-cycle pulse from the SPI master when a transaction completes.
REQ-008 SHALL have input rd_data, 16 bits: SPI read-back; only [7:0] is used.
REQ-009 SHALL have output ptch_rt, 16 bits signed: assembled raw pitch rate.
REQ-010 SHALL have output AZ, 16 bits signed: assembled raw Z acceleration.
REQ-011 SHALL have output vld, 1 bit: one-cycle pulse when ptch_rt and AZ hold a new, coherent sample.

Function
REQ-012 SHALL double-flop INT into INT_ff2 before any use; INT_ff2 is the only INT value the FSM reads.
REQ-013 Init timer: after reset, counts up each cycle; the FSM leaves INIT_WAIT on the cycle after the timer reaches all ones (65535 when FAST_SIM=0, 511 when FAST_SIM=1).
REQ-014 Init writes, in order: 0x0D02, 0x1053, 0x1150, 0x1460.
REQ-015 Each write SHALL pulse wrt for exactly one cycle with cmd already valid, hold cmd stable, and wait for done before the next transaction.
REQ-016 FSM states: INIT_WAIT, INIT1..INIT4, IDLE, RD_PL, RD_PH, RD_AL, RD_AH, DONE_VLD.
REQ-017 IDLE SHALL be entered after the INIT4 write's done; it waits for INT_ff2==1.
REQ-018 Read sequence from IDLE with INT_ff2 high: read commands 0xA200, 0xA300, 0xAC00, 0xAD00, one transaction each, each started only after the previous done.
REQ-019 On each read's done, rd_data[7:0] SHALL be captured into a holding register: pitch-low, pitch-high, AZ-low or AZ-high respectively.
REQ-020 ptch_rt and AZ SHALL update together, in the cycle after the AZ-high done, as {high, low}.
REQ-021 vld SHALL be high in that same cycle (DONE_VLD) for exactly one cycle; ptch_rt and AZ are never visible half-updated.
REQ-022 After DONE_VLD the FSM returns to IDLE; if INT_ff2 is still high, a new sequence starts on the next cycle.
REQ-023 INT activity during init or during a read sequence SHALL be ignored; no queuing, no abort.
REQ-024 done arriving when no transaction is outstanding SHALL be ignored.
REQ-025 wrt SHALL never assert while a transaction is outstanding.
REQ-026 Worst-case read latency, INT rise to vld: 2 sync cycles + 4 SPI transactions + 4 cycles of FSM overhead.

Reset
REQ-027 On rst_n low, asynchronously: state=INIT_WAIT, timer=0, wrt=0, cmd=0, vld=0, ptch_rt=0, AZ=0, holding registers=0, synchronizer flops=0.
REQ-028 Reset mid-transaction SHALL abandon the transaction and rerun the full init sequence; the SPI master is reset by the same rst_n.

Structure
REQ-029 A shared package SHALL hold the FSM state enum, the four init command constants and the four read addresses.
REQ-030 The two-flop synchronizer SHALL be sub-module inert_int_sync; everything else stays in this module.
REQ-031 The FSM and its output decode SHALL be separate from the data holding registers.

Verification
REQ-032 Reset release, FAST_SIM=1: wrt first pulses 512-513 cycles after reset, with cmd=0x0D02; then 0x1053, 0x1150 and 0x1460, each exactly one cycle after the prior done.
REQ-033 INT high, model returns 0x34, 0x12, 0x78, 0xFF: one vld pulse with ptch_rt=0x1234 and AZ=0xFF78 (negative).
REQ-034 INT held high across two samples: two vld pulses, each sample coherent; no cmd changes while a transaction is outstanding.
REQ-035 INT pulsed during RD_PH: the sequence completes normally and no extra sequence is started afterwards if INT is low.
REQ-036 Spurious done injected in IDLE: no state change, no vld.
REQ-037 rst_n low during RD_AL: all outputs go to 0 immediately; the init sequence reruns from INIT_WAIT.

Source files
------------

// File: rtl/inertial_read_sequencer_pkg.sv
// rtl/inertial_read_sequencer_pkg.sv - shared states and SPI command constants for the inertial read sequencer
// Contents: FSM state encodings, sensor init command words, data register
// addresses and a helper that builds the SPI read command for an address.
package inertial_read_sequencer_pkg;

  localparam int STATE_W = 4;

  // FSM state encodings
  localparam logic [STATE_W-1:0] ST_INIT_WAIT = 4'd0;
  localparam logic [STATE_W-1:0] ST_INIT1     = 4'd1;
  localparam logic [STATE_W-1:0] ST_INIT2     = 4'd2;
  localparam logic [STATE_W-1:0] ST_INIT3     = 4'd3;
  localparam logic [STATE_W-1:0] ST_INIT4     = 4'd4;
  localparam logic [STATE_W-1:0] ST_IDLE      = 4'd5;
  localparam logic [STATE_W-1:0] ST_RD_PL     = 4'd6;
  localparam logic [STATE_W-1:0] ST_RD_PH     = 4'd7;
  localparam logic [STATE_W-1:0] ST_RD_AL     = 4'd8;
  localparam logic [STATE_W-1:0] ST_RD_AH     = 4'd9;
  localparam logic [STATE_W-1:0] ST_DONE_VLD  = 4'd10;

  // Sensor configuration writes, {addr, data}, issued in this order
  localparam logic [15:0] INIT_CMD1 = 16'h0D02;
  localparam logic [15:0] INIT_CMD2 = 16'h1053;
  localparam logic [15:0] INIT_CMD3 = 16'h1150;
  localparam logic [15:0] INIT_CMD4 = 16'h1460;

  // Sensor data register addresses
  localparam logic [7:0] ADDR_PTCH_L = 8'h22;
  localparam logic [7:0] ADDR_PTCH_H = 8'h23;
  localparam logic [7:0] ADDR_AZ_L   = 8'h2C;
  localparam logic [7:0] ADDR_AZ_H   = 8'h2D;

  // Reads set the MSB of the address byte; the data byte is don't-care (0)
  function automatic logic [15:0] rd_cmd(input logic [7:0] addr);
    return {addr | 8'h80, 8'h00};
  endfunction

endpackage

// File: rtl/inert_int_sync.sv
// rtl/inert_int_sync.sv - two-flop synchronizer for the sensor data-ready interrupt
// Ports: clk, rst_n (async active-low), int_async (raw INT pin),
//        int_sync (INT after two flops, safe for the FSM to read).
module inert_int_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic int_async,
  output logic int_sync
);

  logic int_ff1_q, int_ff1_d;
  logic int_ff2_q, int_ff2_d;

  always_comb begin
    int_ff1_d = int_async;
    int_ff2_d = int_ff1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_ff1_q <= 1'b0;
      int_ff2_q <= 1'b0;
    end else begin
      int_ff1_q <= int_ff1_d;
      int_ff2_q <= int_ff2_d;
    end
  end

  assign int_sync = int_ff2_q;

endmodule

// File: rtl/inertial_read_sequencer.sv
// rtl/inertial_read_sequencer.sv - configures an inertial sensor over SPI and reads pitch rate / Z accel on INT
// Ports: clk, rst_n (async active-low), INT (async data-ready),
//        wrt/cmd (SPI transaction launch and command word), done/rd_data
//        (SPI completion and read-back, low byte used), ptch_rt/AZ (signed
//        samples), vld (one-cycle pulse when a new coherent sample is out).
module inertial_read_sequencer
  import inertial_read_sequencer_pkg::*;
#(
  parameter int FAST_SIM = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               INT,
  output logic               wrt,
  output logic [15:0]        cmd,
  input  logic               done,
  input  logic [15:0]        rd_data,
  output logic signed [15:0] ptch_rt,
  output logic signed [15:0] AZ,
  output logic               vld
);

  localparam int TIMER_W = (FAST_SIM != 0) ? 9 : 16;

  logic int_ff2;

  inert_int_sync u_int_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .int_async(INT),
    .int_sync (int_ff2)
  );

  // ---------------------------------------------------------------- FSM
  logic [STATE_W-1:0] state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               wrt_q, wrt_d;
  logic [15:0]        cmd_q, cmd_d;
  logic               vld_q, vld_d;

  // Strobes from the FSM into the holding registers
  logic cap_pl, cap_ph, cap_al, publish;

  // wrt_q is high only in the launch cycle; the SPI master cannot finish in
  // that same cycle, so a done seen then is stray and gets dropped.
  logic done_ok;
  assign done_ok = done && !wrt_q;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    wrt_d   = 1'b0;
    cmd_d   = cmd_q;
    vld_d   = 1'b0;
    cap_pl  = 1'b0;
    cap_ph  = 1'b0;
    cap_al  = 1'b0;
    publish = 1'b0;

    case (state_q)
      ST_INIT_WAIT: begin
        timer_d = timer_q + TIMER_W'(1);
        if (&timer_q) begin
          state_d = ST_INIT1;
          wrt_d   = 1'b1;
          cmd_d   = INIT_CMD1;
        end
      end
      ST_INIT1: begin
        if (done_ok) begin
          state_d = ST_INIT2;
          wrt_d   = 1'b1;
          cmd_d   = INIT_CMD2;
        end
      end
      ST_INIT2: begin
        if (done_ok) begin
          state_d = ST_INIT3;
          wrt_d   = 1'b1;
          cmd_d   = INIT_CMD3;
        end
      end
      ST_INIT3: begin
        if (done_ok) begin
          state_d = ST_INIT4;
          wrt_d   = 1'b1;
          cmd_d   = INIT_CMD4;
        end
      end
      ST_INIT4: begin
        if (done_ok) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (int_ff2) begin
          state_d = ST_RD_PL;
          wrt_d   = 1'b1;
          cmd_d   = rd_cmd(ADDR_PTCH_L);
        end
      end
      ST_RD_PL: begin
        if (done_ok) begin
          cap_pl  = 1'b1;
          state_d = ST_RD_PH;
          wrt_d   = 1'b1;
          cmd_d   = rd_cmd(ADDR_PTCH_H);
        end
      end
      ST_RD_PH: begin
        if (done_ok) begin
          cap_ph  = 1'b1;
          state_d = ST_RD_AL;
          wrt_d   = 1'b1;
          cmd_d   = rd_cmd(ADDR_AZ_L);
        end
      end
      ST_RD_AL: begin
        if (done_ok) begin
          cap_al  = 1'b1;
          state_d = ST_RD_AH;
          wrt_d   = 1'b1;
          cmd_d   = rd_cmd(ADDR_AZ_H);
        end
      end
      ST_RD_AH: begin
        if (done_ok) begin
          // Outputs and vld are loaded on this same edge so the whole
          // sample becomes visible at once in DONE_VLD.
          publish = 1'b1;
          vld_d   = 1'b1;
          state_d = ST_DONE_VLD;
        end
      end
      ST_DONE_VLD: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_INIT_WAIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT_WAIT;
      timer_q <= '0;
      wrt_q   <= 1'b0;
      cmd_q   <= 16'h0000;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      wrt_q   <= wrt_d;
      cmd_q   <= cmd_d;
      vld_q   <= vld_d;
    end
  end

  assign wrt = wrt_q;
  assign cmd = cmd_q;
  assign vld = vld_q;

  // --------------------------------------------------- holding registers
  logic [7:0]  ptch_l_q, ptch_l_d;
  logic [7:0]  ptch_h_q, ptch_h_d;
  logic [7:0]  az_l_q, az_l_d;
  logic [7:0]  az_h_q, az_h_d;
  logic [15:0] ptch_q, ptch_d;
  logic [15:0] az_q, az_d;

  always_comb begin
    ptch_l_d = ptch_l_q;
    ptch_h_d = ptch_h_q;
    az_l_d   = az_l_q;
    az_h_d   = az_h_q;
    ptch_d   = ptch_q;
    az_d     = az_q;
    if (cap_pl) ptch_l_d = rd_data[7:0];
    if (cap_ph) ptch_h_d = rd_data[7:0];
    if (cap_al) az_l_d   = rd_data[7:0];
    if (publish) begin
      // AZ-high arrives on this edge, so take it straight from rd_data
      az_h_d = rd_data[7:0];
      ptch_d = {ptch_h_q, ptch_l_q};
      az_d   = {rd_data[7:0], az_l_q};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptch_l_q <= 8'h00;
      ptch_h_q <= 8'h00;
      az_l_q   <= 8'h00;
      az_h_q   <= 8'h00;
      ptch_q   <= 16'h0000;
      az_q     <= 16'h0000;
    end else begin
      ptch_l_q <= ptch_l_d;
      ptch_h_q <= ptch_h_d;
      az_l_q   <= az_l_d;
      az_h_q   <= az_h_d;
      ptch_q   <= ptch_d;
      az_q     <= az_d;
    end
  end

  assign ptch_rt = ptch_q;
  assign AZ      = az_q;

  // Upper read-back byte carries nothing for this sensor
  logic unused_rd_hi;
  assign unused_rd_hi = ^rd_data[15:8];

endmodule

// File: tb/tb_inertial_read_sequencer.sv
// tb/tb_inertial_read_sequencer.sv - scoreboard bench for inertial_read_sequencer with an SPI slave model
module tb_inertial_read_sequencer;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               INT = 1'b0;
  logic               done;
  logic               wrt;
  logic [15:0]        cmd;
  logic [15:0]        rd_data = 16'h0000;
  logic signed [15:0] ptch_rt;
  logic signed [15:0] AZ;
  logic               vld;

  logic mdl_done  = 1'b0;
  logic spur_done = 1'b0;
  assign done = mdl_done | spur_done;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [15:0] exp_cmd[$];
  logic [7:0]  rd_bytes[$];
  logic [15:0] exp_pt[$];
  logic [15:0] exp_az[$];

  logic        busy = 1'b0;
  int          cnt = 0;
  logic [15:0] cmd_lat = 16'h0000;
  logic [15:0] e_cmd;
  logic [15:0] e_pt;
  logic [15:0] e_az;
  int          last_done_cyc = 0;
  int          rst_rel_cyc = 0;
  int          lat;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  inertial_read_sequencer #(.FAST_SIM(1)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .INT    (INT),
    .wrt    (wrt),
    .cmd    (cmd),
    .done   (done),
    .rd_data(rd_data),
    .ptch_rt(ptch_rt),
    .AZ     (AZ),
    .vld    (vld)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // SPI slave model plus output monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      busy     = 1'b0;
      mdl_done = 1'b0;
      cnt      = 0;
      rd_data  = 16'h0000;
    end else begin
      if (mdl_done) begin
        mdl_done = 1'b0;
        busy     = 1'b0;
        rd_data  = 16'h0000;
      end
      if (wrt) begin
        chk("wrt_while_outstanding", {31'd0, busy}, 32'd0);
        if (exp_cmd.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_wrt: got cmd 0x%0h expected no transaction", cmd);
        end else begin
          e_cmd = exp_cmd.pop_front();
          chk("wrt_cmd", {16'd0, cmd}, {16'd0, e_cmd});
          if (cmd == 16'h0D02) begin
            lat = cyc - rst_rel_cyc;
            n_checks++;
            if (lat < 512 || lat > 513) begin
              n_errors++;
              $display("FAIL init_wrt_latency: got %0d cycles expected 512..513", lat);
            end
          end else if (cmd != 16'hA200) begin
            chk("wrt_gap_after_done", cyc - last_done_cyc, 32'd1);
          end
        end
        busy    = 1'b1;
        cnt     = 3;
        cmd_lat = cmd;
      end else if (busy) begin
        if (cnt > 1) begin
          cnt--;
        end else begin
          chk("cmd_stable_while_outstanding", {16'd0, cmd}, {16'd0, cmd_lat});
          mdl_done      = 1'b1;
          last_done_cyc = cyc;
          if (cmd_lat[15]) begin
            if (rd_bytes.size() == 0) begin
              n_checks++;
              n_errors++;
              $display("FAIL read_data_underrun: got read 0x%0h expected no read", cmd_lat);
              rd_data = 16'h0000;
            end else begin
              rd_data = {8'hA5, rd_bytes.pop_front()};
            end
          end else begin
            rd_data = 16'h0000;
          end
        end
      end
      if (vld) begin
        if (exp_pt.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_vld: got ptch_rt 0x%0h AZ 0x%0h expected no vld", ptch_rt, AZ);
        end else begin
          e_pt = exp_pt.pop_front();
          e_az = exp_az.pop_front();
          chk("vld_ptch_rt", {16'd0, ptch_rt}, {16'd0, e_pt});
          chk("vld_az", {16'd0, AZ}, {16'd0, e_az});
        end
      end
    end
  end

  task automatic push_init();
    exp_cmd.push_back(16'h0D02);
    exp_cmd.push_back(16'h1053);
    exp_cmd.push_back(16'h1150);
    exp_cmd.push_back(16'h1460);
  endtask

  task automatic push_read(input logic [7:0] pl, input logic [7:0] ph,
                           input logic [7:0] al, input logic [7:0] ah);
    exp_cmd.push_back(16'hA200);
    exp_cmd.push_back(16'hA300);
    exp_cmd.push_back(16'hAC00);
    exp_cmd.push_back(16'hAD00);
    rd_bytes.push_back(pl);
    rd_bytes.push_back(ph);
    rd_bytes.push_back(al);
    rd_bytes.push_back(ah);
    exp_pt.push_back({ph, pl});
    exp_az.push_back({ah, al});
  endtask

  task automatic wait_wrt_cmd(input logic [15:0] c);
    bit seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (wrt && cmd == c) seen = 1'b1;
    end
    if (!seen) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_wrt_timeout: got no wrt expected cmd 0x%0h", c);
    end
  endtask

  task automatic wait_drain(input string nm);
    bit empty = 1'b0;
    for (int i = 0; i < 3000 && !empty; i++) begin
      @(negedge clk);
      if (exp_cmd.size() == 0 && exp_pt.size() == 0 && !busy) empty = 1'b1;
    end
    if (!empty) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_timeout: got %0d cmds %0d samples pending expected 0",
               nm, exp_cmd.size(), exp_pt.size());
    end
    repeat (5) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_wrt", {31'd0, wrt}, 32'd0);
    chk("rst_cmd", {16'd0, cmd}, 32'd0);
    chk("rst_vld", {31'd0, vld}, 32'd0);
    chk("rst_ptch_rt", {16'd0, ptch_rt}, 32'd0);
    chk("rst_az", {16'd0, AZ}, 32'd0);

    // Init sequence
    push_init();
    rst_n = 1'b1;
    rst_rel_cyc = cyc;
    wait_drain("init");

    // Single sample, negative AZ
    push_read(8'h34, 8'h12, 8'h78, 8'hFF);
    INT = 1'b1;
    wait_wrt_cmd(16'hA200);
    INT = 1'b0;
    wait_drain("read1");
    chk("az_is_negative", {31'd0, (AZ < 0)}, 32'd1);
    chk("ptch_rt_held", {16'd0, ptch_rt}, 32'h1234);

    // INT held across two samples
    push_read(8'h01, 8'h80, 8'h00, 8'h80);
    push_read(8'h11, 8'h22, 8'h33, 8'h44);
    INT = 1'b1;
    wait_wrt_cmd(16'hA200);
    wait_wrt_cmd(16'hA200);
    INT = 1'b0;
    wait_drain("read2x");

    // INT pulsed again during RD_PH is ignored
    push_read(8'h5A, 8'h00, 8'h00, 8'h01);
    INT = 1'b1;
    wait_wrt_cmd(16'hA200);
    INT = 1'b0;
    wait_wrt_cmd(16'hA300);
    INT = 1'b1;
    repeat (2) @(negedge clk);
    INT = 1'b0;
    wait_drain("int_in_rdph");
    repeat (40) @(negedge clk);

    // Spurious done in IDLE
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    repeat (20) @(negedge clk);
    push_read(8'h7F, 8'hFF, 8'h01, 8'h00);
    INT = 1'b1;
    wait_wrt_cmd(16'hA200);
    INT = 1'b0;
    wait_drain("after_spurious");

    // Reset during RD_AL
    exp_cmd.push_back(16'hA200);
    exp_cmd.push_back(16'hA300);
    exp_cmd.push_back(16'hAC00);
    rd_bytes.push_back(8'h01);
    rd_bytes.push_back(8'h02);
    INT = 1'b1;
    wait_wrt_cmd(16'hAC00);
    INT = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_wrt", {31'd0, wrt}, 32'd0);
    chk("midrst_cmd", {16'd0, cmd}, 32'd0);
    chk("midrst_vld", {31'd0, vld}, 32'd0);
    chk("midrst_ptch_rt", {16'd0, ptch_rt}, 32'd0);
    chk("midrst_az", {16'd0, AZ}, 32'd0);
    exp_cmd.delete();
    rd_bytes.delete();
    repeat (3) @(negedge clk);
    push_init();
    rst_n = 1'b1;
    rst_rel_cyc = cyc;
    wait_drain("reinit");

    // Normal read after re-init
    push_read(8'hCD, 8'hAB, 8'h00, 8'h7F);
    INT = 1'b1;
    wait_wrt_cmd(16'hA200);
    INT = 1'b0;
    wait_drain("read_after_reinit");

    chk("queues_empty", exp_cmd.size() + exp_pt.size() + rd_bytes.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
